apb4_regbank_slave: RTL and testbench

// - Parametrised APB4 completer fronting a bank of NUM_REGS read/write registers.
// - Adds over the basic APB pin set: PSTRB byte strobes, programmable wait states,

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_regbank_core.sv | 73 +++++++
 rtl/apb4_regbank_slave.sv | 153 +++++++++++++++
 tb/tb_apb4_regbank_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer types and helpers.
// FSM state encoding, wait-state limit, strobe width.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  localparam int APB_MAX_WAIT = 15;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb_regbank_core.sv
// Register storage with byte-strobe writes, registered read mux and write pulses.
// Ports: clk/rst, write port (wr_*), read load/clear (rd_*), rdata, regs, wr_pulse.
module apb_regbank_core
  import apb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic                       rd_load,
  input  logic                       rd_clr,
  input  logic                       rd_err,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int STRB = strb_w(DATA_W);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Pulse follows the commit edge; zero-strobe writes still pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_en) begin
        wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // Read data is held for the whole access, then cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_load) begin
      rdata <= rd_err ? '0 : mem[rd_idx];
    end else if (rd_clr) begin
      rdata <= '0;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i*DATA_W +: DATA_W] = mem[i];
    end
  end

endmodule

// File: rtl/apb4_regbank_slave.sv
// APB4 completer for a NUM_REGS x DATA_W register bank with wait states.
// Ports: APB4 completer pins (PCLK..PSLVERR), regs_o flat contents, wr_pulse_o.
module apb4_regbank_slave
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  input  logic [DATA_W/8-1:0]        PSTRB,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int STRB  = strb_w(DATA_W);
  localparam int SH    = $clog2(STRB);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WAIT_C =
    (WAIT_CYCLES > APB_MAX_WAIT) ? APB_MAX_WAIT : WAIT_CYCLES;

  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(STRB - 1);
  localparam logic [ADDR_W-1:0] NREG  = ADDR_W'(NUM_REGS);
  localparam logic [3:0]        WAITV = 4'(WAIT_C);

  apb_state_e state, state_nxt;

  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   off;
  logic [ADDR_W-1:0]   word;
  logic [IDX_W-1:0]    idx_d;
  logic                err_d;
  logic [IDX_W-1:0]    idx_q;
  logic                err_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB-1:0]     strb_q;
  logic                ready;
  logic                commit;
  logic                rd_clr;

  // Decode on the live bus; captured when leaving SETUP.
  always_comb begin
    off   = PADDR - BASE_ADDR;
    word  = off >> SH;
    idx_d = word[IDX_W-1:0];
    err_d = (PADDR < BASE_ADDR)
         || (word >= NREG)
         || ((PADDR & AMASK) != '0);
  end

  // Only state and cnt feed PREADY, so no bus-to-PREADY path.
  assign ready   = (state == APB_ACCESS) && (cnt == WAITV);
  assign commit  = ready && wr_q && !err_q;
  assign rd_clr  = (state == APB_ACCESS) && (ready || !PSEL);
  assign PREADY  = ready;
  assign PSLVERR = ready && err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= APB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      APB_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt = APB_SETUP;
        end
      end
      APB_SETUP: begin
        state_nxt = APB_ACCESS;
      end
      APB_ACCESS: begin
        // A dropped PSEL before ready is an abort.
        if (ready) begin
          if (PSEL && !PENABLE) begin
            state_nxt = APB_SETUP;
          end else begin
            state_nxt = APB_IDLE;
          end
        end else if (!PSEL) begin
          state_nxt = APB_IDLE;
        end
      end
      default: begin
        state_nxt = APB_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if ((state == APB_ACCESS) && !ready) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (state == APB_SETUP) begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  apb_regbank_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_core (
    .clk      (PCLK),
    .rst      (PRESET),
    .wr_en    (commit),
    .wr_idx   (idx_q),
    .wr_data  (wdata_q),
    .wr_strb  (strb_q),
    .rd_load  (state == APB_SETUP),
    .rd_clr   (rd_clr),
    .rd_err   (err_d),
    .rd_idx   (idx_d),
    .rdata    (PRDATA),
    .regs     (regs_o),
    .wr_pulse (wr_pulse_o)
  );

endmodule

// File: tb/tb_apb4_regbank_slave.sv
// Randomized APB4 bench with a register-array model for three wait settings.
// DUT d uses WAIT_CYCLES = 0, 2, 3 for d = 0, 1, 2.
module tb_apb4_regbank_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [2:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;

  logic [31:0]  prd [3];
  logic         rdy [3];
  logic         slv [3];
  logic [511:0] rg  [3];
  logic [15:0]  pls [3];

  logic [31:0] model [3][16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb4_regbank_slave #(
      .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
    ) u_dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .PSEL       (psel[g]),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PSTRB      (PSTRB),
      .PRDATA     (prd[g]),
      .PREADY     (rdy[g]),
      .PSLVERR    (slv[g]),
      .regs_o     (rg[g]),
      .wr_pulse_o (pls[g])
    );
  end

  function automatic int wt(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        model[d][i] = '0;
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk({tag, "_rdy"}, rdy[d], 0);
    chk({tag, "_slv"}, slv[d], 0);
    chk({tag, "_prd"}, prd[d], 0);
    chk({tag, "_pls"}, pls[d], 0);
  endtask

  // One full APB transfer on DUT d, checked against the model.
  task automatic txn(input int d, input bit wr,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] st);
    bit          e;
    int          ix;
    int          n;
    bit          done;
    logic [31:0] erd;
    logic [15:0] epl;
    e   = (a >= 32'd64) || (a[1:0] != 2'b00);
    ix  = e ? 0 : int'(a >> 2);
    erd = e ? 32'h0 : model[d][ix];
    psel    = '0;
    psel[d] = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = wd;
    PSTRB   = st;
    n    = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge PCLK); #1;
      n++;
      PENABLE = 1'b1;
      if (rdy[d]) done = 1;
      else chk("slverr_low", slv[d], 0);
      if (!wr && n >= 2) chk("prdata", prd[d], erd);
    end
    chk("latency", 32'(n), 32'(2 + wt(d)));
    chk("pslverr", slv[d], e);
    if (wr && !e) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][ix][b*8 +: 8] = wd[b*8 +: 8];
    end
    epl = (wr && !e) ? (16'h1 << ix) : 16'h0;
    @(posedge PCLK); #1;
    chk("wr_pulse", pls[d], epl);
    chk("prdata_idle", prd[d], 0);
    if (!e) chk("reg", rg[d][ix*32 +: 32], model[d][ix]);
  endtask

  task automatic idle(input int d);
    psel    = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pulse_once", pls[d], 0);
    chk("idle_rdy", rdy[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          d;
    bit          wr;
    int          cat;
    logic [31:0] a;

    PRESET  = 1'b1;
    psel    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PSTRB   = '0;
    model_clear();
    repeat (3) @(posedge PCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_quiet(k, "rst");
      chk("rst_regs", rg[k] == '0, 1);
    end
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk_quiet(0, "post_rst");

    // Basic write/read.
    txn(0, 1, 32'h04, 32'hDEADBEEF, 4'hF);
    chk("pulse_lit", pls[0], 16'h0002);
    idle(0);
    txn(0, 0, 32'h04, 32'h0, 4'h0);
    idle(0);

    // Partial strobes.
    txn(0, 1, 32'h00, 32'h11223344, 4'hF);
    idle(0);
    txn(0, 1, 32'h00, 32'hAABBCCDD, 4'h5);
    idle(0);
    txn(0, 0, 32'h00, 32'h0, 4'h0);
    chk("strb_lit", rg[0][31:0], 32'h11BB33DD);
    idle(0);

    // Zero-strobe write pulses but changes nothing.
    txn(0, 1, 32'h00, 32'hFFFFFFFF, 4'h0);
    idle(0);

    // Wait states, read data stable.
    txn(2, 1, 32'h04, 32'hCAFE0123, 4'hF);
    idle(2);
    txn(2, 0, 32'h04, 32'h0, 4'h0);
    idle(2);

    // Errors.
    txn(0, 1, 32'h40, 32'h12345678, 4'hF);
    idle(0);
    txn(0, 0, 32'h02, 32'h0, 4'h0);
    idle(0);
    chk("err_regs", rg[0][63:32], 32'hDEADBEEF);

    // PENABLE high in IDLE is ignored.
    psel    = 3'b001;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 32'h08;
    repeat (4) begin
      @(posedge PCLK); #1;
      chk("penable_idle", rdy[0], 0);
    end
    idle(0);

    // Abort on DUT 1 (two wait states).
    psel    = 3'b010;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h0C;
    PWDATA  = 32'h55AA55AA;
    PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_pre", rdy[1], 0);
    psel    = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk_quiet(1, "abort");
    @(posedge PCLK); #1;
    chk_quiet(1, "abort2");
    chk("abort_reg", rg[1][96 +: 32], model[1][3]);
    txn(1, 0, 32'h0C, 32'h0, 4'h0);
    idle(1);

    // Back-to-back write then read.
    txn(0, 1, 32'h08, 32'h0BADF00D, 4'hF);
    txn(0, 0, 32'h08, 32'h0, 4'h0);
    idle(0);

    // Reset in the middle of a write on DUT 2.
    txn(2, 1, 32'h10, 32'h77777777, 4'hF);
    idle(2);
    psel    = 3'b100;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h10;
    PWDATA  = 32'h99999999;
    PSTRB   = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    #1;
    chk_quiet(2, "mid_rst");
    chk("mid_rst_regs", rg[2] == '0, 1);
    model_clear();
    psel    = '0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    txn(2, 0, 32'h10, 32'h0, 4'h0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      d   = $urandom_range(0, 2);
      wr  = 1'($urandom_range(0, 1));
      cat = $urandom_range(0, 9);
      if (cat == 0)
        a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else if (cat == 1)
        a = ($urandom | 32'h40) & 32'hFFFFFFFC;
      else
        a = 32'($urandom_range(0, 15)) << 2;
      txn(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) idle(d);
    end
    idle(0);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        chk("final_reg", rg[k][i*32 +: 32], model[k][i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
